// File: rtl/matrix_vector_streaming.sv
// Streaming matrix-vector multiplier.
// A DIM x DIM weight matrix is loaded row-major, then each incoming vector is
// multiplied against it one MAC per cycle, and one result per row is emitted
// on a valid/ready stream. Weights persist across vectors until a reload is
// requested with io_reload.
module matrix_vector_streaming #(
  parameter int DIM       = 4,
  parameter int IN_WIDTH  = 4,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_weight_in_valid,
  output logic                 io_weight_in_ready,
  input  logic [IN_WIDTH-1:0]  io_weight_in_bits,
  input  logic                 io_value_in_valid,
  output logic                 io_value_in_ready,
  input  logic [IN_WIDTH-1:0]  io_value_in_bits,
  output logic                 io_value_out_valid,
  input  logic                 io_value_out_ready,
  output logic [ACC_WIDTH-1:0] io_value_out_bits,
  input  logic                 io_reload,
  output logic                 io_busy
);

  localparam int KW   = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1;
  localparam int IDXW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW   = 2 * IN_WIDTH;

  localparam logic [KW-1:0]   K_LAST   = KW'(DIM * DIM - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIM - 1);

  typedef enum logic [1:0] {
    LOAD_W,
    LOAD_V,
    COMPUTE,
    EMIT
  } state_t;

  state_t state, next_state;

  logic [KW-1:0]        k;
  logic [IDXW-1:0]      j;
  logic [IDXW-1:0]      row;
  logic [IDXW-1:0]      col;
  logic [ACC_WIDTH-1:0] acc;
  logic                 reload_flag;

  logic [IN_WIDTH-1:0]  w_mem [DIM*DIM];
  logic [IN_WIDTH-1:0]  v_mem [DIM];

  logic                 w_fire;
  logic                 v_fire;
  logic                 o_fire;
  logic [KW-1:0]        w_addr;
  logic [IN_WIDTH-1:0]  w_rd;
  logic [IN_WIDTH-1:0]  v_rd;
  logic [PW-1:0]        prod_u;
  logic signed [PW-1:0] prod_s;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc_sum;

  assign w_fire = io_weight_in_valid & io_weight_in_ready;
  assign v_fire = io_value_in_valid & io_value_in_ready;
  assign o_fire = io_value_out_valid & io_value_out_ready;

  // Operand fetch for the current MAC: W[row][col] and V[col].
  assign w_addr = KW'(row) * KW'(DIM) + KW'(col);
  assign w_rd   = w_mem[w_addr];
  assign v_rd   = v_mem[col];

  // Full-width product in both interpretations; SIGNED selects which is used.
  assign prod_u = PW'(w_rd) * PW'(v_rd);
  assign prod_s = PW'($signed(w_rd)) * PW'($signed(v_rd));

  // Extend the product to accumulator width (sign- or zero-extension).
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    prod_ext = ACC_WIDTH'(prod_u);
    if (SIGNED != 0) prod_ext = ACC_WIDTH'(prod_s);
  end

  assign acc_sum = acc + prod_ext;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= LOAD_W;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      LOAD_W:  if (w_fire && k == K_LAST) next_state = LOAD_V;
      LOAD_V:  if (v_fire && j == IDX_LAST) next_state = COMPUTE;
      COMPUTE: if (col == IDX_LAST) next_state = EMIT;
      EMIT: begin
        if (o_fire) begin
          if (row != IDX_LAST)  next_state = COMPUTE;
          else if (reload_flag) next_state = LOAD_W;
          else                  next_state = LOAD_V;
        end
      end
      default: next_state = LOAD_W;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    io_weight_in_ready = 1'b0;
    io_value_in_ready  = 1'b0;
    io_value_out_valid = 1'b0;
    io_busy            = 1'b0;
    if (!reset) begin
      io_weight_in_ready = (state == LOAD_W);
      io_value_in_ready  = (state == LOAD_V);
      io_value_out_valid = (state == EMIT);
      io_busy            = (state == COMPUTE) || (state == EMIT);
    end
  end

  // Weight and vector storage, written only on accepted transfers.
  always_ff @(posedge clock) begin
    // NOTE: the storage arrays have no reset; the counters alone decide which
    // entries are valid, so stale contents are never used.
    if (w_fire) w_mem[k] <= io_weight_in_bits;
    if (v_fire) v_mem[j] <= io_value_in_bits;
  end

  // Counters, accumulator, result register and sticky reload flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k                 <= '0;
      j                 <= '0;
      row               <= '0;
      col               <= '0;
      acc               <= '0;
      io_value_out_bits <= '0;
      reload_flag       <= 1'b0;
    end else begin
      if (state != LOAD_W && next_state == LOAD_W) reload_flag <= 1'b0;
      else if (io_reload && state != LOAD_W)       reload_flag <= 1'b1;

      case (state)
        LOAD_W: begin
          if (w_fire) k <= (k == K_LAST) ? '0 : k + KW'(1);
        end
        LOAD_V: begin
          if (v_fire) begin
            if (j == IDX_LAST) begin
              j   <= '0;
              row <= '0;
              col <= '0;
              acc <= '0;
            end else begin
              j <= j + IDXW'(1);
            end
          end
        end
        COMPUTE: begin
          if (col == IDX_LAST) begin
            io_value_out_bits <= acc_sum;
          end else begin
            acc <= acc_sum;
            col <= col + IDXW'(1);
          end
        end
        EMIT: begin
          if (o_fire) begin
            col <= '0;
            acc <= '0;
            if (row != IDX_LAST) begin
              row <= row + IDXW'(1);
            end else begin
              row <= '0;
              j   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_streaming.sv
// Directed testbench for matrix_vector_streaming.
// Four instances share one stimulus stream and differ only in parameters:
//   dut_u : IN_WIDTH 8, unsigned, 32-bit acc (main functional checks)
//   dut_n : IN_WIDTH 4, unsigned, 32-bit acc
//   dut_s : IN_WIDTH 4, signed,   32-bit acc
//   dut_w : IN_WIDTH 4, unsigned,  8-bit acc (wrap-around)
// All four follow the same control flow, so handshakes are driven from dut_u.
module tb_matrix_vector_streaming;

  localparam int DIM = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        w_valid;
  logic [7:0]  w_bits;
  logic        v_valid;
  logic [7:0]  v_bits;
  logic        o_ready;
  logic        reload;

  logic        w_ready_u, v_ready_u, o_valid_u, busy_u;
  logic [31:0] o_bits_u;
  logic        w_ready_n, v_ready_n, o_valid_n, busy_n;
  logic [31:0] o_bits_n;
  logic        w_ready_s, v_ready_s, o_valid_s, busy_s;
  logic [31:0] o_bits_s;
  logic        w_ready_w, v_ready_w, o_valid_w, busy_w;
  logic [7:0]  o_bits_w;

  logic [31:0] snap_n;
  logic [31:0] snap_s;
  logic [7:0]  snap_w;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  matrix_vector_streaming #(.DIM(DIM), .IN_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset),
    .io_weight_in_valid(w_valid), .io_weight_in_ready(w_ready_u), .io_weight_in_bits(w_bits),
    .io_value_in_valid(v_valid), .io_value_in_ready(v_ready_u), .io_value_in_bits(v_bits),
    .io_value_out_valid(o_valid_u), .io_value_out_ready(o_ready), .io_value_out_bits(o_bits_u),
    .io_reload(reload), .io_busy(busy_u)
  );

  matrix_vector_streaming #(.DIM(DIM), .IN_WIDTH(4), .ACC_WIDTH(32), .SIGNED(0)) dut_n (
    .clock(clock), .reset(reset),
    .io_weight_in_valid(w_valid), .io_weight_in_ready(w_ready_n), .io_weight_in_bits(w_bits[3:0]),
    .io_value_in_valid(v_valid), .io_value_in_ready(v_ready_n), .io_value_in_bits(v_bits[3:0]),
    .io_value_out_valid(o_valid_n), .io_value_out_ready(o_ready), .io_value_out_bits(o_bits_n),
    .io_reload(reload), .io_busy(busy_n)
  );

  matrix_vector_streaming #(.DIM(DIM), .IN_WIDTH(4), .ACC_WIDTH(32), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset),
    .io_weight_in_valid(w_valid), .io_weight_in_ready(w_ready_s), .io_weight_in_bits(w_bits[3:0]),
    .io_value_in_valid(v_valid), .io_value_in_ready(v_ready_s), .io_value_in_bits(v_bits[3:0]),
    .io_value_out_valid(o_valid_s), .io_value_out_ready(o_ready), .io_value_out_bits(o_bits_s),
    .io_reload(reload), .io_busy(busy_s)
  );

  matrix_vector_streaming #(.DIM(DIM), .IN_WIDTH(4), .ACC_WIDTH(8), .SIGNED(0)) dut_w (
    .clock(clock), .reset(reset),
    .io_weight_in_valid(w_valid), .io_weight_in_ready(w_ready_w), .io_weight_in_bits(w_bits[3:0]),
    .io_value_in_valid(v_valid), .io_value_in_ready(v_ready_w), .io_value_in_bits(v_bits[3:0]),
    .io_value_out_valid(o_valid_w), .io_value_out_ready(o_ready), .io_value_out_bits(o_bits_w),
    .io_reload(reload), .io_busy(busy_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_weight(input logic [7:0] x);
    int n;
    @(negedge clock);
    w_valid = 1'b1;
    w_bits  = x;
    n = 0;
    while (!w_ready_u && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("w_ready", w_ready_u, 1'b1);
    @(posedge clock);
    #1;
    w_valid = 1'b0;
  endtask

  task automatic send_value(input logic [7:0] x);
    int n;
    @(negedge clock);
    v_valid = 1'b1;
    v_bits  = x;
    n = 0;
    while (!v_ready_u && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("v_ready", v_ready_u, 1'b1);
    @(posedge clock);
    #1;
    v_valid = 1'b0;
  endtask

  // Wait for a result with o_ready high; the transfer cycle plus DIM compute
  // cycles means valid is first seen on the (DIM+1)th negedge sample.
  task automatic recv(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!o_valid_u && n < 50);
    check({tag, "_valid"}, o_valid_u, 1'b1);
    check(tag, o_bits_u, exp);
    check({tag, "_lat"}, n, DIM + 1);
    snap_n = o_bits_n;
    snap_s = o_bits_s;
    snap_w = o_bits_w;
    @(posedge clock);
    #1;
  endtask

  task automatic send_vector(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    send_value(a);
    send_value(b);
    send_value(c);
    send_value(d);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    w_valid = 1'b0;
    w_bits  = '0;
    v_valid = 1'b0;
    v_bits  = '0;
    o_ready = 1'b0;
    reload  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_w_ready", w_ready_u, 1'b0);
    check("rst_v_ready", v_ready_u, 1'b0);
    check("rst_o_valid", o_valid_u, 1'b0);
    check("rst_busy", busy_u, 1'b0);
    check("rst_bits", o_bits_u, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_w_ready", w_ready_u, 1'b1);
    check("post_rst_v_ready", v_ready_u, 1'b0);

    // Weights 1..16, values 1..4.
    o_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send_weight(8'(i));
    check("after_w_v_ready", v_ready_u, 1'b1);
    send_vector(8'd1, 8'd2, 8'd3, 8'd4);
    @(negedge clock);
    check("compute_busy", busy_u, 1'b1);
    check("compute_v_ready", v_ready_u, 1'b0);
    check("compute_o_valid", o_valid_u, 1'b0);
    // Already consumed one negedge above; the remaining DIM are waited here.
    n = 1;
    while (!o_valid_u && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("first_lat", n, DIM + 1);
    check("row0", o_bits_u, 32'd30);
    @(posedge clock);
    #1;
    recv("row1", 32'd70);
    recv("row2", 32'd110);
    recv("row3", 32'd150);

    // Backpressure on row 0 with a weight offered during EMIT.
    o_ready = 1'b0;
    send_vector(8'd1, 8'd2, 8'd3, 8'd4);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!o_valid_u && n < 50);
    check("bp_valid_seen", o_valid_u, 1'b1);
    w_valid = 1'b1;
    w_bits  = 8'hAA;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("bp_valid", o_valid_u, 1'b1);
      check("bp_bits", o_bits_u, 32'd30);
      check("bp_v_ready", v_ready_u, 1'b0);
      check("bp_w_ready", w_ready_u, 1'b0);
    end
    w_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clock);
    #1;
    recv("bp_row1", 32'd70);
    recv("bp_row2", 32'd110);
    recv("bp_row3", 32'd150);

    // Reload requested during a vector; next matrix is the identity.
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    send_vector(8'd1, 8'd2, 8'd3, 8'd4);
    recv("rl_row0", 32'd30);
    recv("rl_row1", 32'd70);
    recv("rl_row2", 32'd110);
    recv("rl_row3", 32'd150);
    check("rl_w_ready", w_ready_u, 1'b1);
    check("rl_v_ready", v_ready_u, 1'b0);
    for (int i = 0; i < 16; i++) begin
      reload = (i == 5);
      send_weight((i % 5 == 0) ? 8'd1 : 8'd0);
    end
    reload = 1'b0;
    send_vector(8'd3, 8'd5, 8'd7, 8'd9);
    recv("id_row0", 32'd3);
    recv("id_row1", 32'd5);
    recv("id_row2", 32'd7);
    recv("id_row3", 32'd9);
    // Reload raised during LOAD_W is ignored: back to LOAD_V, not LOAD_W.
    check("ign_v_ready", v_ready_u, 1'b1);
    check("ign_w_ready", w_ready_u, 1'b0);

    // Reload again, then an all-0xF matrix for the signed/unsigned/wrap cases.
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    send_vector(8'd1, 8'd1, 8'd1, 8'd1);
    for (int r = 0; r < DIM; r++) recv("id_ones", 32'd1);
    check("f_w_ready", w_ready_u, 1'b1);
    for (int i = 0; i < 16; i++) send_weight(8'h0F);
    send_vector(8'd1, 8'd1, 8'd1, 8'd1);
    for (int r = 0; r < DIM; r++) begin
      recv("f1_u", 32'd60);
      check("f1_unsigned4", snap_n, 32'd60);
      check("f1_signed", snap_s, 32'hFFFF_FFFC);
      check("f1_acc8", {24'd0, snap_w}, 32'd60);
    end
    send_vector(8'd15, 8'd15, 8'd15, 8'd15);
    for (int r = 0; r < DIM; r++) begin
      recv("ff_u", 32'd900);
      check("ff_unsigned4", snap_n, 32'd900);
      check("ff_signed", snap_s, 32'd4);
      check("ff_wrap8", {24'd0, snap_w}, 32'd132);
    end

    // Reset during COMPUTE clears the outputs without a clock edge.
    send_vector(8'd2, 8'd4, 8'd6, 8'd8);
    repeat (2) @(negedge clock);
    check("pre_rst_busy", busy_u, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_bits_u", o_bits_u, 32'd0);
    check("mid_rst_bits_w", {24'd0, o_bits_w}, 32'd0);
    check("mid_rst_busy", busy_u, 1'b0);
    check("mid_rst_o_valid", o_valid_u, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel_w_ready", w_ready_u, 1'b1);
    check("rel_v_ready", v_ready_u, 1'b0);
    for (int i = 0; i < 15; i++) send_weight((i % 5 == 0) ? 8'd1 : 8'd0);
    check("w15_v_ready", v_ready_u, 1'b0);
    check("w15_w_ready", w_ready_u, 1'b1);
    send_weight(8'd1);
    check("w16_v_ready", v_ready_u, 1'b1);
    send_vector(8'd2, 8'd4, 8'd6, 8'd8);
    recv("rr_row0", 32'd2);
    recv("rr_row1", 32'd4);
    recv("rr_row2", 32'd6);
    recv("rr_row3", 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_vector_streaming.md
MATRIX_VECTOR_STREAMING -- requirements
Module: matrix_vector_streaming

Interface
REQ-001 Parameter DIM, default 4, matrix dimension and vector length; legal range 2..16.
REQ-002 Parameter IN_WIDTH, default 4, width of weight and value elements.
REQ-003 Parameter ACC_WIDTH, default 32, accumulator and result width; must be >= 2*IN_WIDTH.
REQ-004 Parameter SIGNED, default 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 io_weight_in_valid / io_weight_in_ready / io_weight_in_bits  in / out / in  1 / 1 / IN_WIDTH  weight stream, row-major order.
REQ-009 io_value_in_valid / io_value_in_ready / io_value_in_bits  in / out / in  1 / 1 / IN_WIDTH  vector element stream, index 0 first.
REQ-010 io_value_out_valid / io_value_out_ready / io_value_out_bits  out / in / out  1 / 1 / ACC_WIDTH  result stream, row 0 first.
REQ-011 io_reload  input  1  request to replace the weight matrix after the current vector.
REQ-012 io_busy  output  1  high in COMPUTE or EMIT.

Function
REQ-013 Transfers SHALL occur only on cycles where valid and ready are both high at the rising clock edge.
REQ-014 The FSM SHALL have states LOAD_W, LOAD_V, COMPUTE and EMIT.
REQ-015 LOAD_W: io_weight_in_ready=1; each transfer stores W[k/DIM][k%DIM], k increments; after transfer DIM*DIM-1 the FSM goes to LOAD_V with k=0.
REQ-016 LOAD_V: io_value_in_ready=1; each transfer stores V[j], j increments; after transfer DIM-1 the FSM goes to COMPUTE with row=0, col=0, acc=0.
REQ-017 COMPUTE: one MAC per cycle, acc <= acc + ext(W[row][col]*V[col]); col increments; on col=DIM-1, io_value_out_bits <= acc + product and the FSM goes to EMIT.
REQ-018 EMIT: io_value_out_valid=1; io_value_out_bits SHALL be held stable until the transfer occurs.
REQ-019 EMIT transfer with row<DIM-1: row increments, col=0, acc=0, next state COMPUTE.
REQ-020 EMIT transfer with row=DIM-1: next state LOAD_W if the reload flag is set, otherwise LOAD_V; j=0.
REQ-021 Latency: first result valid DIM+1 cycles after the final value transfer; minimum DIM+1 cycles per row under continuous io_value_out_ready.
REQ-022 Product width SHALL be 2*IN_WIDTH, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH; accumulation SHALL wrap modulo 2^ACC_WIDTH without saturation.
REQ-023 A high io_reload in any cycle SHALL set a sticky reload flag; the flag SHALL clear on entry to LOAD_W; io_reload while already in LOAD_W SHALL be ignored.
REQ-024 Ready signals SHALL be low in COMPUTE and EMIT; inputs presented then SHALL be neither consumed nor stored.
REQ-025 io_value_out_valid SHALL be low outside EMIT; io_value_out_ready is don't-care outside EMIT.
REQ-026 Weights SHALL persist across vectors until reload; W and V storage need not be reset.

Reset
REQ-027 While reset is high: state=LOAD_W, k=j=row=col=0, acc=0, reload flag=0, io_value_out_bits=0, and all valid/ready outputs and io_busy low.
REQ-028 On the first cycle after reset deasserts, io_weight_in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard the partial matrix, vector and accumulator immediately, without waiting for a clock edge.

Verification
REQ-030 DIM=4, unsigned: weights 1..16, values 1,2,3,4 -> outputs 30, 70, 110, 150 in order.
REQ-031 SIGNED=1: all weights 4'hF, values all 4'h1 -> four outputs 32'hFFFFFFFC; the same stimulus with SIGNED=0 -> four outputs 60.
REQ-032 Backpressure: hold io_value_out_ready=0 for 10 cycles in EMIT -> valid stays 1, bits unchanged, io_value_in_ready=0; release -> next row result follows DIM+1 cycles later.
REQ-033 Reload: pulse io_reload during the second vector; after its 4th output, io_weight_in_ready=1; load the identity matrix, then values 3,5,7,9 -> outputs 3,5,7,9.
REQ-034 Wrap: ACC_WIDTH=8, all weights and values 15 -> each output 900 mod 256 = 132.
REQ-035 Reset during COMPUTE -> outputs 0 immediately; after release, 16 weights are required before any value is accepted.
